prbs31_burst_ctrl: RTL and testbench



---
 rtl/prbs31_burst_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_prbs31_burst_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_burst_ctrl
//  Description : Command-driven sequencer around a 32-bit parallel PRBS31
//                engine (x^31 + x^28 + 1, 32 bits per step). Byte commands
//                load a seed and launch bursts of 1..256 words. Each word is
//                streamed out little-endian as bytes over a valid/ready
//                handshake. Completion is reported with a one-cycle pulse.
//  Optional    : define PRBS_ERRINJ_EN to invert bit 0 of every ERR_PERIOD-th
//                output byte. Only the output is altered, not the sequence.
//  Ports       : clk        - single rising-edge clock
//                rst_n      - synchronous reset, active HIGH (legacy name)
//                cmd_valid  / cmd_ready  - command handshake
//                cmd_op     - 00 NOP, 01 LOAD_SEED_BYTE, 10 START, 11 NOP
//                cmd_data   - seed byte, or burst length minus one
//                abort      - terminate a running burst
//                out_data   / out_valid / out_ready - byte stream
//                busy       - burst in progress
//                done       - pulse on normal burst completion
//                seed_err   - pulse when a zero seed was replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs31_burst_ctrl #(
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
    parameter int unsigned ERR_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       abort,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       seed_err
);

    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_START = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    generate
        if (ERR_PERIOD < 1 || ERR_PERIOD > 255) begin : g_err_period_check
            $error("prbs31_burst_ctrl: ERR_PERIOD must be within 1..255");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_seed_sr;
    logic [31:0] r_word;
    logic [7:0]  r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic        r_done;
    logic        r_seed_err;

    logic        w_load;
    logic        w_start;
    logic        w_hs;
    logic        w_last_hs;
    logic        w_zero_seed;
    logic [31:0] w_commit;
    logic [7:0]  w_byte;

    // 32 serial PRBS31 shifts collapsed into one step. s[31] is outside the
    // 31-bit recurrence, so it never feeds the next state.
    function automatic logic [31:0] f_step(input logic [31:0] s);
        logic [31:0] n;
        n = '0;
        for (int i = 4; i < 32; i++) begin
            n[i] = s[i-1] ^ s[i-4];
        end
        n[3] = s[2] ^ s[30] ^ s[27];
        n[2] = s[1] ^ s[29] ^ s[26];
        n[1] = s[0] ^ s[28] ^ s[25];
        n[0] = s[30] ^ s[24];
        return n;
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_load       = (r_state == ST_IDLE) && cmd_valid && (cmd_op == c_OP_LOAD);
        w_start      = (r_state == ST_IDLE) && cmd_valid && (cmd_op == c_OP_START);
        // An all-zero 31-bit state would lock the LFSR; bit 31 does not help.
        w_zero_seed  = (r_seed_sr[30:0] == 31'd0);
        w_commit     = w_zero_seed ? SEED_DEFAULT : r_seed_sr;
        w_hs         = (r_state == ST_RUN) && out_ready;
        w_last_hs    = w_hs && (r_byte_idx == 2'd3) && (r_word_cnt == 8'd0);

        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_RUN;
            ST_RUN:  if (abort || w_last_hs) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        case (r_byte_idx)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_seed_sr  <= SEED_DEFAULT;
            r_word     <= SEED_DEFAULT;
            r_word_cnt <= 8'd0;
            r_byte_idx <= 2'd0;
            r_done     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_seed_err <= 1'b0;

            if (w_load) begin
                r_seed_sr <= {r_seed_sr[23:0], cmd_data};
            end

            if (w_start) begin
                r_word     <= f_step(w_commit);
                r_word_cnt <= cmd_data;
                r_byte_idx <= 2'd0;
                r_seed_err <= w_zero_seed;
            end

            // Abort wins over a coincident final handshake: no done and the
            // seed register keeps its pre-burst value.
            if (w_hs && !abort) begin
                if (r_byte_idx != 2'd3) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end else if (r_word_cnt != 8'd0) begin
                    r_byte_idx <= 2'd0;
                    r_word_cnt <= r_word_cnt - 8'd1;
                    r_word     <= f_step(r_word);
                end else begin
                    r_done    <= 1'b1;
                    // The last emitted word becomes the next seed, so a
                    // following START continues the sequence seamlessly.
                    r_seed_sr <= r_word;
                end
            end
        end
    end

`ifdef PRBS_ERRINJ_EN
    localparam logic [7:0] c_ERR_LAST = 8'(ERR_PERIOD - 1);

    logic [7:0] r_err_cnt;
    logic       w_err_hit;

    assign w_err_hit = (r_err_cnt == c_ERR_LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_start) begin
            r_err_cnt <= 8'd0;
        end else if (w_hs) begin
            r_err_cnt <= w_err_hit ? 8'd0 : (r_err_cnt + 8'd1);
        end
    end

    assign out_data = (r_state == ST_RUN) ? (w_byte ^ {7'd0, w_err_hit}) : 8'd0;
`else
    assign out_data = (r_state == ST_RUN) ? w_byte : 8'd0;
`endif

    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign cmd_ready = (r_state == ST_IDLE);
    assign done      = r_done;
    assign seed_err  = r_seed_err;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs31_burst_ctrl
//  Description : Self-checking bench for prbs31_burst_ctrl. A transaction
//                model built on a bit-serial PRBS31 LFSR predicts every output
//                cycle. Directed tests pin the model with hand-computed bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs31_burst_ctrl;

    localparam int TB_ERR_PERIOD = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [7:0] cmd_data  = 8'h00;
    logic       abort     = 1'b0;
    logic       out_ready = 1'b1;
    logic       cmd_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       seed_err;

    prbs31_burst_ctrl #(
        .SEED_DEFAULT (32'h0000_0001),
        .ERR_PERIOD   (TB_ERR_PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .seed_err  (seed_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial Fibonacci LFSR, 32 shifts per word.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < 32; k++) begin
            r = {r[30:0], r[30] ^ r[27]};
        end
        return r;
    endfunction

    // Byte as it should appear at position idx of a burst.
    function automatic logic [7:0] exp_byte(input logic [7:0] v, input int idx);
`ifdef PRBS_ERRINJ_EN
        if ((idx % TB_ERR_PERIOD) == TB_ERR_PERIOD - 1) return v ^ 8'h01;
`endif
        return v;
    endfunction

    // ---------------- transaction model ----------------
    logic [31:0] m_seed = 32'h1;
    logic [31:0] m_final = 32'h0;
    logic [31:0] m_w;
    logic [7:0]  m_q[$];
    bit          m_run  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_serr = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            m_seed = 32'h1;
            m_run  = 1'b0;
            m_done = 1'b0;
            m_serr = 1'b0;
            m_q.delete();
        end else begin
            m_done = 1'b0;
            m_serr = 1'b0;
            if (!m_run) begin
                if (cmd_valid && cmd_op == 2'b01) begin
                    m_seed = {m_seed[23:0], cmd_data};
                end else if (cmd_valid && cmd_op == 2'b10) begin
                    m_w = m_seed;
                    if (m_w[30:0] == 31'd0) begin
                        m_w    = 32'h1;
                        m_serr = 1'b1;
                    end
                    for (int k = 0; k <= int'(cmd_data); k++) begin
                        m_w = m_step(m_w);
                        for (int b = 0; b < 4; b++) begin
                            m_q.push_back(exp_byte(m_w[8*b +: 8], m_q.size()));
                        end
                    end
                    m_final = m_w;
                    m_run   = 1'b1;
                end
            end else begin
                if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (abort) begin
                    m_q.delete();
                    m_run = 1'b0;
                end else if (m_q.size() == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_seed = m_final;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_run});
            chk("busy",      {31'd0, busy},      {31'd0, m_run});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_run});
            chk("done",      {31'd0, done},      {31'd0, m_done});
            chk("seed_err",  {31'd0, seed_err},  {31'd0, m_serr});
            if (m_run) begin
                if (m_q.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
                else chk("model_queue_nonempty", 32'd0, 32'd1);
            end
        end
    end

    // ---------------- capture / stall monitor ----------------
    logic [7:0] cap[$];
    int         hs_count   = 0;
    int         done_cnt   = 0;
    int         serr_cnt   = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (prev_stall && out_valid) chk("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
        if (out_valid === 1'b1 && out_ready) begin
            cap.push_back(out_data);
            hs_count++;
        end
        if (done === 1'b1)     done_cnt++;
        if (seed_err === 1'b1) serr_cnt++;
    end

    // ---------------- sink ready pattern ----------------
    bit bp_mode = 1'b0;
    int cyc     = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        out_ready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        chk("cmd_accept_wait", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
    endtask

    task automatic load_seed(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) send(2'b01, s[8*i +: 8]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        chk("hs_wait", (hs_count >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_stats();
        cap.delete();
        done_cnt = 0;
        serr_cnt = 0;
    endtask

    // Compare captured bytes against up to two hand-computed words.
    task automatic chk_cap(input string name, input int nw, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        chk({name, "_len"}, cap.size(), 4 * nw);
        for (int i = 0; i < 4 * nw && i < cap.size(); i++) begin
            w = (i < 4) ? w0 : w1;
            chk(name, {24'd0, cap[i]}, {24'd0, exp_byte(w[8*(i%4) +: 8], i)});
        end
    endtask

    // ---------------- directed tests ----------------
    int base;

    initial begin
        // Model pinned to hand-derived step values.
        chk("model_step_1",     m_step(32'h0000_0001), 32'h0000_0012);
        chk("model_step_12",    m_step(32'h0000_0012), 32'h0000_0104);
        chk("model_step_104",   m_step(32'h0000_0104), 32'h0000_1248);
        chk("model_step_1248",  m_step(32'h0000_1248), 32'h0001_0010);

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_seed_err",  {31'd0, seed_err},  32'd0);
        rst_n = 1'b0;
        tick();

        // Basic two-word burst from seed 1.
        clear_stats();
        load_seed(32'h0000_0001);
        send(2'b10, 8'h01);
        wait_idle(100);
        chk_cap("t1_bytes", 2, 32'h0000_0012, 32'h0000_0104);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_serr_cnt", serr_cnt, 0);

        // Continuation from the last emitted word, twice.
        clear_stats();
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t2_bytes", 1, 32'h0000_1248, 32'h0);
        clear_stats();
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t2b_bytes", 1, 32'h0001_0010, 32'h0);
        chk("t2_done_cnt", done_cnt, 1);

        // Zero seed, and a seed whose only set bit is outside the recurrence.
        clear_stats();
        load_seed(32'h0000_0000);
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t3_bytes", 1, 32'h0000_0012, 32'h0);
        chk("t3_serr_cnt", serr_cnt, 1);
        clear_stats();
        load_seed(32'h8000_0000);
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t3b_bytes", 1, 32'h0000_0012, 32'h0);
        chk("t3b_serr_cnt", serr_cnt, 1);

        // Backpressure.
        clear_stats();
        load_seed(32'h0000_0001);
        bp_mode = 1'b1;
        send(2'b10, 8'h01);
        wait_idle(200);
        bp_mode = 1'b0;
        chk_cap("t4_bytes", 2, 32'h0000_0012, 32'h0000_0104);
        chk("t4_done_cnt", done_cnt, 1);

        // Abort in the middle of a long burst.
        clear_stats();
        load_seed(32'h0000_0001);
        send(2'b10, 8'hFF);
        base = hs_count;
        wait_hs(base + 5, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        tick();
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_bytes_len", cap.size(), 6);
        clear_stats();
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t5_seed_kept", 1, 32'h0000_0012, 32'h0);

        // Abort coincident with the final handshake.
        clear_stats();
        load_seed(32'h0000_0001);
        send(2'b10, 8'h00);
        base = hs_count;
        wait_hs(base + 3, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        chk("t6_done_cnt", done_cnt, 0);
        chk("t6_bytes_len", cap.size(), 4);
        clear_stats();
        send(2'b10, 8'h00);
        wait_idle(100);
        chk_cap("t6_seed_kept", 1, 32'h0000_0012, 32'h0);

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        tick();
        chk("t7_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t7_busy",      {31'd0, busy},      32'd0);
        abort = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
